mem_responder: RTL



---
 rtl/sys_defs.sv | 27 ++
 rtl/mem_return_arbiter.sv | 23 ++
 rtl/mem_responder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/sys_defs.sv
// rtl/sys_defs.sv - shared bus command, slot state and memory-model defaults
package sys_defs;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        MS_FREE      = 2'h0,
        MS_PENDING   = 2'h1,
        MS_RETURNING = 2'h2
    } MEM_SLOT_STATE;

    localparam int DEF_MEM_LATENCY     = 10;
    localparam int DEF_NUM_MEM_TAGS    = 15;
    localparam int DEF_MEM_DEPTH_WORDS = 8192;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Fibonacci LFSR, taps 16,14,13,11
    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

endpackage

// File: rtl/mem_return_arbiter.sv
// rtl/mem_return_arbiter.sv - combinational lowest-index priority encoder
// Grants the lowest set bit of eligible_i and reports it as a 1-based tag (0 = none).
module mem_return_arbiter #(
    parameter int N     = 15,
    parameter int TAG_W = 4
) (
    input  logic [N-1:0]     eligible_i,
    output logic [N-1:0]     grant_o,
    output logic [TAG_W-1:0] tag_o
);

    always_comb begin
        grant_o = '0;
        tag_o   = '0;
        for (int i = 0; i < N; i++) begin
            if (eligible_i[i] && (grant_o == '0)) begin
                grant_o[i] = 1'b1;
                tag_o      = TAG_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - tagged fixed-latency main-memory responder
// Optional macro MEM_LATENCY_JITTER_EN adds 0..3 LFSR-driven extra cycles per transaction.
module mem_responder
    import sys_defs::*;
#(
    parameter int  NUM_MEM_TAGS    = DEF_NUM_MEM_TAGS,
    parameter int  MEM_LATENCY     = DEF_MEM_LATENCY,
    parameter int  MEM_DEPTH_WORDS = DEF_MEM_DEPTH_WORDS,
    localparam int TAG_W           = $clog2(NUM_MEM_TAGS + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  BUS_COMMAND       proc2mem_command,
    input  logic [31:0]      proc2mem_addr,
    input  logic [63:0]      proc2mem_data,
    output logic [TAG_W-1:0] mem2proc_response,
    output logic [63:0]      mem2proc_data,
    output logic [TAG_W-1:0] mem2proc_tag
);

    localparam int IDX_W = $clog2(MEM_DEPTH_WORDS);
    localparam int CNT_W = 9;

    MEM_SLOT_STATE    state_q [NUM_MEM_TAGS];
    MEM_SLOT_STATE    state_d [NUM_MEM_TAGS];
    logic [CNT_W-1:0] cnt_q   [NUM_MEM_TAGS];
    logic [CNT_W-1:0] cnt_d   [NUM_MEM_TAGS];
    logic [63:0]      buf_q   [NUM_MEM_TAGS];
    logic [63:0]      mem_q   [MEM_DEPTH_WORDS];

    logic [NUM_MEM_TAGS-1:0] free_vec;
    logic [NUM_MEM_TAGS-1:0] elig_vec;
    logic [NUM_MEM_TAGS-1:0] alloc_grant;
    logic [NUM_MEM_TAGS-1:0] ret_grant;
    logic [TAG_W-1:0]        alloc_tag;
    logic [TAG_W-1:0]        ret_tag;
    logic [TAG_W-1:0]        tag_q;
    logic [63:0]             data_q;
    logic [63:0]             ret_data;
    logic [IDX_W-1:0]        idx;
    logic                    accept;
    logic                    is_store;
    logic [CNT_W-1:0]        load_cnt;
    logic                    unused_addr_bits;

    // Upper address bits are dropped so the word index wraps modulo the depth.
    assign idx              = proc2mem_addr[IDX_W+2:3];
    assign unused_addr_bits = ^{proc2mem_addr[31:IDX_W+3], proc2mem_addr[2:0]};

`ifdef MEM_LATENCY_JITTER_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= lfsr_next(lfsr_q);
    end

    assign load_cnt = CNT_W'(MEM_LATENCY - 2) + CNT_W'(lfsr_q[1:0]);
`else
    assign load_cnt = CNT_W'(MEM_LATENCY - 2);
`endif

    mem_return_arbiter #(.N(NUM_MEM_TAGS), .TAG_W(TAG_W)) u_alloc (
        .eligible_i (free_vec),
        .grant_o    (alloc_grant),
        .tag_o      (alloc_tag)
    );

    mem_return_arbiter #(.N(NUM_MEM_TAGS), .TAG_W(TAG_W)) u_return (
        .eligible_i (elig_vec),
        .grant_o    (ret_grant),
        .tag_o      (ret_tag)
    );

    assign mem2proc_response = (proc2mem_command != BUS_NONE) ? alloc_tag : '0;
    assign accept            = (mem2proc_response != '0);
    assign is_store          = (proc2mem_command == BUS_STORE);

    assign mem2proc_tag  = tag_q;
    assign mem2proc_data = data_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_MEM_TAGS; i++) begin
                state_q[i] <= MS_FREE;
                cnt_q[i]   <= '0;
                buf_q[i]   <= '0;
            end
            tag_q  <= '0;
            data_q <= '0;
        end else begin
            for (int i = 0; i < NUM_MEM_TAGS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                // Loads snapshot the array before this edge's store lands.
                if (accept && alloc_grant[i]) begin
                    buf_q[i] <= is_store ? proc2mem_data : mem_q[idx];
                end
            end
            tag_q  <= ret_tag;
            data_q <= ret_data;
        end
    end

    // Backing store is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (accept && is_store) begin
            mem_q[idx] <= proc2mem_data;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_MEM_TAGS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                MS_FREE: begin
                    if (accept && alloc_grant[i]) begin
                        state_d[i] = MS_PENDING;
                        cnt_d[i]   = load_cnt;
                    end
                end
                MS_PENDING: begin
                    if (ret_grant[i]) begin
                        state_d[i] = MS_RETURNING;
                    end else if (cnt_q[i] != '0) begin
                        cnt_d[i] = cnt_q[i] - CNT_W'(1);
                    end
                end
                MS_RETURNING: state_d[i] = MS_FREE;
                default:      state_d[i] = MS_FREE;
            endcase
        end
    end

    always_comb begin
        free_vec = '0;
        elig_vec = '0;
        ret_data = '0;
        for (int i = 0; i < NUM_MEM_TAGS; i++) begin
            free_vec[i] = (state_q[i] == MS_FREE);
            elig_vec[i] = (state_q[i] == MS_PENDING) && (cnt_q[i] == '0);
            if (ret_grant[i]) begin
                ret_data = buf_q[i];
            end
        end
    end

endmodule
